// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory access stage.
package dmem_pkg;
    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 255;
    localparam logic [31:0] DMEM_ERR_WORD = 32'hDEADBEEF;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} dmem_state_e;

    // Wait counter is never narrower than 8 bits.
    function automatic int cnt_width(input int t);
        return ($clog2(t + 1) > 8) ? $clog2(t + 1) : 8;
    endfunction
endpackage

// File: rtl/dmem_timer.sv
// BUSY-phase wait counter; flags expiry in the TIMEOUT-th BUSY cycle.
module dmem_timer
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic busy,
    output logic expired
);
    localparam int CW = cnt_width(TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     cnt <= '0;
        else if (start) cnt <= '0;
        else if (busy)  cnt <= cnt + 1'b1;
    end

    // cnt holds k-1 during the k-th BUSY cycle.
    assign expired = busy && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/dmem_stage.sv
// Memory-access stage: req/ack handshake to variable-latency data memory, stalls the core.
// Optional macro DMEM_TIMEOUT_EN adds a wait timeout and the bus_err output.
module dmem_stage
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              stall,
    output logic              misalign,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
`ifdef DMEM_TIMEOUT_EN
    output logic              bus_err,
`endif
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);
    dmem_state_e state;
    logic access, aligned, go, busy;

    assign access  = memread | memwrite;
    assign aligned = (addr[1:0] == 2'b00);
    assign go      = (state == IDLE) && access && aligned;
    assign busy    = (state == BUSY);

    // Gated by reset so the core is never frozen while the stage is held in reset.
    assign stall = reset && (go || busy);

`ifdef DMEM_TIMEOUT_EN
    logic expired;

    dmem_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (go),
        .busy    (busy),
        .expired (expired)
    );
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            readdata  <= '0;
            misalign  <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef DMEM_TIMEOUT_EN
            bus_err   <= 1'b0;
`endif
        end else begin
            misalign <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            bus_err  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    misalign <= access && !aligned;
                    if (go) begin
                        mem_req   <= 1'b1;
                        mem_we    <= memwrite;
                        mem_addr  <= addr;
                        mem_wdata <= writedata;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) readdata <= mem_rdata;
                        state   <= DONE;
                    end
`ifdef DMEM_TIMEOUT_EN
                    else if (expired) begin
                        mem_req <= 1'b0;
                        if (!mem_we) readdata <= DATA_W'(DMEM_ERR_WORD);
                        bus_err <= 1'b1;
                        state   <= DONE;
                    end
`endif
                end
                // One cycle with no request evaluation so the same instruction is not reissued.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_stage.sv
// Randomized self-checking bench for dmem_stage; the bench plays the data memory.
module tb_dmem_stage;
`ifdef DMEM_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        memread, memwrite, mem_ack;
    logic [31:0] addr, writedata, mem_rdata;
    logic [31:0] readdata, mem_addr, mem_wdata;
    logic        stall, misalign, mem_req, mem_we;
`ifdef DMEM_TIMEOUT_EN
    logic        bus_err;
`endif

    int total = 0;
    int bad = 0;
    logic [31:0] exp_rd = 32'h0;
    logic [31:0] mem [int unsigned];
    int rises = 0;
    logic req_q = 1'b0;

    always #5 clk = ~clk;

    dmem_stage #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
        .addr(addr), .writedata(writedata), .readdata(readdata), .stall(stall),
        .misalign(misalign), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef DMEM_TIMEOUT_EN
        .bus_err(bus_err),
`endif
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always @(negedge clk) begin
        if (mem_req && !req_q) rises++;
        req_q = mem_req;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Runs one instruction starting just after a rising edge; lat=0 means the memory never acks.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input int lat, input logic [31:0] rdat,
                          input string nm);
        int stalls = 0, reqs = 0, errs = 0, exp_reqs;
        bit done = 0;
        logic [31:0] exp_after;
        exp_reqs  = (lat == 0) ? TB_TIMEOUT : lat;
        exp_after = (rd && !wr) ? ((lat == 0) ? 32'hDEADBEEF : rdat) : exp_rd;
        memread = rd; memwrite = wr; addr = a; writedata = wd;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (stall) stalls++;
`ifdef DMEM_TIMEOUT_EN
            if (bus_err) errs++;
`endif
            total++;
            if (misalign !== 1'b0) begin bad++; $display("FAIL %s misalign: got %b want 0", nm, misalign); end
            if (mem_req) begin
                reqs++;
                total++;
                if (mem_addr !== a || mem_we !== wr || (wr && mem_wdata !== wd) || readdata !== exp_rd) begin
                    bad++;
                    $display("FAIL %s busy-hold: addr=%h we=%b wdata=%h rd=%h want addr=%h we=%b wdata=%h rd=%h",
                             nm, mem_addr, mem_we, mem_wdata, readdata, a, wr, wd, exp_rd);
                end
                if (lat != 0 && reqs == lat) begin mem_ack = 1'b1; mem_rdata = rdat; end
            end else if (stalls > 0 && !stall) begin
                done = 1;
                total++;
                if (readdata !== exp_after) begin
                    bad++; $display("FAIL %s readdata: got %h want %h", nm, readdata, exp_after);
                end
            end
            @(posedge clk); #1;
            mem_ack = 1'b0; mem_rdata = $urandom;
        end
        exp_rd = exp_after;
        memread = 1'b0; memwrite = 1'b0;
        total++;
        if (!done) begin bad++; $display("FAIL %s complete: access never finished", nm); end
        total++;
        if (stalls != exp_reqs + 1 || reqs != exp_reqs) begin
            bad++; $display("FAIL %s latency: stalls=%0d reqs=%0d want stalls=%0d reqs=%0d",
                            nm, stalls, reqs, exp_reqs + 1, exp_reqs);
        end
        total++;
        if (errs != ((lat == 0) ? 1 : 0) && TB_TIMEOUT == 4) begin
            bad++; $display("FAIL %s bus_err: pulses=%0d want %0d", nm, errs, (lat == 0) ? 1 : 0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; memread = 1'b1; memwrite = 1'b0; addr = 32'h40; writedata = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        total++;
        if ({readdata, stall, misalign, mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
            bad++; $display("FAIL reset: rd=%h stall=%b mis=%b req=%b we=%b maddr=%h mwd=%h want all 0",
                            readdata, stall, misalign, mem_req, mem_we, mem_addr, mem_wdata);
        end
        memread = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
    endtask

    task automatic test_load();
        access(1'b1, 1'b0, 32'h10, 32'h0, 3, 32'h1234_5678, "load");
    endtask

    task automatic test_store();
        access(1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 1, 32'h0, "store");
        mem[32'h20] = 32'hCAFE_F00D;
    endtask

    task automatic test_misalign();
        memread = 1'b1; addr = 32'h13;
        @(negedge clk);
        total++;
        if (stall !== 1'b0 || mem_req !== 1'b0) begin
            bad++; $display("FAIL misalign-nostall: stall=%b req=%b want 0 0", stall, mem_req);
        end
        @(posedge clk); #1 memread = 1'b0;
        @(negedge clk);
        total++;
        if (misalign !== 1'b1 || readdata !== exp_rd || mem_req !== 1'b0) begin
            bad++; $display("FAIL misalign-pulse: mis=%b rd=%h req=%b want 1 %h 0", misalign, readdata, mem_req, exp_rd);
        end
        @(negedge clk);
        total++;
        if (misalign !== 1'b0) begin bad++; $display("FAIL misalign-width: got %b want 0", misalign); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int r0;
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        total++;
        if (mem_req !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL idle-ack: req=%b stall=%b want 0 0", mem_req, stall);
        end
        @(posedge clk); #1 mem_ack = 1'b0;
        @(negedge clk);
        total++;
        if (readdata !== exp_rd) begin bad++; $display("FAIL idle-ack-rd: got %h want %h", readdata, exp_rd); end
        @(posedge clk); #1;
        r0 = rises;
        access(1'b1, 1'b0, 32'h20, 32'h0, 2, mem[32'h20], "b2b-0");
        access(1'b1, 1'b0, 32'h24, 32'h0, 1, 32'h5555_AAAA, "b2b-1");
        total++;
        if (rises - r0 != 2) begin bad++; $display("FAIL b2b-reqs: got %0d want 2", rises - r0); end
    endtask

    task automatic test_reset_mid();
        int busy_seen = 0;
        memread = 1'b1; memwrite = 1'b0; addr = 32'h80;
        for (int c = 0; c < 20 && busy_seen < 2; c++) begin
            @(negedge clk);
            if (mem_req) busy_seen++;
        end
        reset = 1'b0;
        #1;
        total++;
        if (mem_req !== 1'b0 || stall !== 1'b0 || readdata !== 32'h0) begin
            bad++; $display("FAIL reset-mid: req=%b stall=%b rd=%h want 0 0 0", mem_req, stall, readdata);
        end
        exp_rd = 32'h0;
        memread = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        @(posedge clk); #1 mem_ack = 1'b0;
        @(negedge clk);
        total++;
        if (mem_req !== 1'b0 || stall !== 1'b0 || readdata !== 32'h0) begin
            bad++; $display("FAIL late-ack: req=%b stall=%b rd=%h want 0 0 0", mem_req, stall, readdata);
        end
        @(posedge clk); #1;
        access(1'b1, 1'b0, 32'h84, 32'h0, 2, 32'h0BAD_F00D, "post-reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic rd, wr;
            logic [31:0] a, wd, rdat;
            int lat;
            rd  = 1'($urandom);
            wr  = 1'($urandom) | ~rd;
            a   = {24'h0, 4'($urandom), 2'($urandom), 2'b00};
            wd  = $urandom;
            lat = $urandom_range(1, 6);
            rdat = mem.exists(a) ? mem[a] : $urandom;
            access(rd, wr, a, wd, lat, rdat, "random");
            if (wr) mem[a] = wd;
            else    mem[a] = rdat;
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
    endtask

`ifdef DMEM_TIMEOUT_EN
    task automatic test_timeout();
        access(1'b1, 1'b0, 32'h30, 32'h0, 0, 32'h0, "timeout");
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_store();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef DMEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_stage.md
Name: dmem_stage

Overview:
- Memory-access stage directly downstream of the datapath ALU.
- Consumes the ALU result (address), store data and memory-control strobes.
- Runs a req/ack handshake to a variable-latency data memory and stalls the core until the access completes.
- Returns load data to the core's result mux.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, data word width.
TIMEOUT, 255, max wait cycles for mem_ack (used only with DMEM_TIMEOUT_EN).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
memread  input  1  load request from control.
memwrite  input  1  store request from control.
addr  input  ADDR_W  byte address (ALU result).
writedata  input  DATA_W  store data.
readdata  output  DATA_W  registered load data to the result mux.
stall  output  1  freeze PC and pipeline while high.
misalign  output  1  one-cycle pulse on an access with addr[1:0]!=0.
mem_req  output  1  request to data memory.
mem_we  output  1  1=write, 0=read; valid with mem_req.
mem_addr  output  ADDR_W  latched word address.
mem_wdata  output  DATA_W  latched store data.
mem_ack  input  1  one-cycle completion pulse from memory.
mem_rdata  input  DATA_W  read data; valid in the mem_ack cycle.

Behaviour:
- Interface fixed: one clock; reset is asynchronous and active-low.
- Reset values: readdata=0, stall=0, misalign=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, state=IDLE.
- Word accesses only.
- An access with addr[1:0]!=0:
  - pulses misalign for one cycle;
  - issues no request and does not stall;
  - leaves readdata unchanged.
- memread and memwrite both high: treated as a write.
- IDLE:
  - stall = (memread|memwrite) & aligned, combinational, so the core freezes in the same cycle.
  - On that condition: latch addr, writedata and we at the edge, set mem_req=1, go to BUSY.
- BUSY:
  - mem_req, mem_we, mem_addr, mem_wdata held stable; stall=1.
  - On mem_ack: mem_req=0 at the edge; for a read, readdata<=mem_rdata; go to DONE.
  - A write leaves readdata unchanged.
- DONE (exactly one cycle):
  - stall=0; the core advances at this edge using the registered readdata.
  - No new request is evaluated in DONE, which prevents reissuing the same instruction.
  - Next state IDLE.
- Latency:
  - An access acked N cycles after mem_req rises stalls the core for N+1 cycles.
  - Minimum N=1, giving 2 stall cycles.
- mem_ack outside BUSY is ignored.
- Reset asserted mid-access:
  - all outputs return to reset values asynchronously and mem_req drops immediately;
  - the pending transaction is abandoned and a late ack is ignored.
- readdata holds its last value until the next completed read.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined:
  - an 8-bit+ wait counter clears on entry to BUSY and increments each BUSY cycle;
  - if it reaches TIMEOUT without mem_ack: mem_req drops, readdata<=32'hDEADBEEF for a read, extra output bus_err pulses for one cycle, FSM goes to DONE.
- Undefined: BUSY waits indefinitely, with no bus_err port and no counter.

Decomposition:
- Shared package dmem_pkg:
  - state enum (IDLE, BUSY, DONE);
  - DMEM_ERR_WORD = 32'hDEADBEEF;
  - default widths.
- One natural sub-module, dmem_timer: the timeout counter, instantiated only under DMEM_TIMEOUT_EN.
- The FSM and the latches stay in dmem_stage.

Test Plan:
- Load: memread=1, addr=0x0000_0010, memory acks 3 cycles after mem_req with rdata=0x1234_5678 -> stall high 4 cycles; mem_addr=0x10, mem_we=0 held throughout; readdata=0x1234_5678 in DONE; stall low in DONE.
- Store: memwrite=1, addr=0x20, writedata=0xCAFE_F00D, ack after 1 cycle -> mem_we=1, mem_wdata=0xCAFE_F00D, 2 stall cycles, readdata unchanged.
- Misaligned: memread=1, addr=0x0000_0013 -> misalign pulses 1 cycle; mem_req and stall stay 0.
- Back-to-back: two loads on consecutive instructions -> exactly two mem_req assertions, each separated by one DONE cycle; spurious ack in IDLE has no effect.
- Reset mid-access: assert reset (low) 2 cycles into BUSY -> mem_req, stall, readdata go to 0 immediately; after release, ack arriving is ignored; state IDLE.
- With DMEM_TIMEOUT_EN, TIMEOUT=4: load with no ack -> mem_req drops after 4 BUSY cycles; bus_err pulses; readdata=0xDEADBEEF; stall releases in DONE.
